// File: rtl/piradip_spi_cs_decoder.sv
// piradip_spi_cs_decoder: registered N_CS-way chip-select decoder with
// break-before-make sequencing (CS setup, CS hold, minimum inter-transaction gap).
// One FSM and one shared down-counter drive a row of per-channel output flops.

// Per-channel chip-select flop: holds the pin at its idle level unless told to assert.
module piradip_spi_cs_lane #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic on_next,
    output logic cs
);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Output flop; async reset forces the idle level immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cs <= IDLE_LVL;
        else     cs <= on_next ? ~IDLE_LVL : IDLE_LVL;
    end
endmodule

module piradip_spi_cs_decoder #(
    parameter int SEL_WIDTH    = 3,
    parameter int N_CS         = 8,
    parameter int ACTIVE_LOW   = 1,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 req,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic                 ready,
    output logic                 busy,
    output logic                 sel_err,
    output logic [N_CS-1:0]      cs
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        HOLD   = 3'd3,
        GAP    = 3'd4
    } state_t;

    // Counter load values are "cycles - 1": the state lasts until the counter reads zero.
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] SETUP_LD = (SETUP_CYCLES > 0) ? CNT_WIDTH'(SETUP_CYCLES - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] HOLD_LD  = (HOLD_CYCLES  > 0) ? CNT_WIDTH'(HOLD_CYCLES  - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] GAP_LD   = (GAP_CYCLES   > 0) ? CNT_WIDTH'(GAP_CYCLES   - 1) : '0;
    // One extra bit so N_CS == 2**SEL_WIDTH still compares correctly.
    localparam logic [SEL_WIDTH:0]   N_CS_W   = (SEL_WIDTH + 1)'(N_CS);

    state_t                 state, state_d;
    logic [CNT_WIDTH-1:0]   cnt, cnt_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   ready_d, busy_d, sel_err_d;
    logic                   sel_ok, cs_on_d;
    logic [N_CS-1:0]        lane_on;

    assign sel_ok = ({1'b0, sel} < N_CS_W);

    // State, counter, latched select and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            sel_q   <= sel_d;
            ready   <= ready_d;
            busy    <= busy_d;
            sel_err <= sel_err_d;
        end
    end

    // Next-state logic; every registered output is derived from the next state so
    // outputs change on the same edge as the state they describe.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sel_d     = sel_q;
        sel_err_d = 1'b0;

        case (state)
            IDLE: begin
                if (req && en) begin
                    if (sel_ok) begin
                        sel_d = sel;
                        if (SETUP_CYCLES == 0) begin
                            state_d = ACTIVE;
                        end else begin
                            state_d = SETUP;
                            cnt_d   = SETUP_LD;
                        end
                    end else begin
                        // Toggle rather than hold, so a stuck bad request shows as pulses.
                        sel_err_d = ~sel_err;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) state_d = ACTIVE;
                else           cnt_d   = cnt - CNT_ONE;
            end
            ACTIVE: begin
                if (!req) begin
                    if (HOLD_CYCLES != 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else if (GAP_CYCLES != 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (GAP_CYCLES != 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - CNT_ONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Losing enable releases CS at once but still enforces the full gap.
        if (!en && state != IDLE) begin
            if (GAP_CYCLES != 0) begin
                state_d = GAP;
                cnt_d   = GAP_LD;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // Registered-output next values.
    always_comb begin
        ready_d = (state_d == ACTIVE);
        busy_d  = (state_d != IDLE);
        cs_on_d = (state_d == SETUP) || (state_d == ACTIVE) || (state_d == HOLD);
    end

    // One lane per chip select; only the lane matching the latched index may assert.
    for (genvar i = 0; i < N_CS; i++) begin : g_lane
        assign lane_on[i] = cs_on_d && (sel_d == SEL_WIDTH'(i));

        piradip_spi_cs_lane #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .on_next (lane_on[i]),
            .cs      (cs[i])
        );
    end
endmodule
